// File: rtl/seg_scan_mux.sv
// Multiplexed digit scanner feeding dec7seg: steps through the digits of a latched value once per slot.
// Optional build macro LEADING_ZERO_BLANK_EN blanks the digits above the most significant nonzero nibble.
module seg_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_mask,
  input  logic                      load,
  output logic [3:0]                dig,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      dp,
  output logic                      frame_done
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_POL = {NUM_DIGITS{ACTIVE_LOW}};

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow_val;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_valid;
  logic [3:0]              r_dig;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_dp;
  logic                    r_frame_done;

  logic                    w_tick;
  logic                    w_wrap;
  logic [IW-1:0]           w_idx_nxt;
  logic [4*NUM_DIGITS-1:0] w_shadow_val_nxt;
  logic [NUM_DIGITS-1:0]   w_shadow_dp_nxt;
  logic [3:0]              w_nib;
  logic                    w_dp_bit;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic                    w_lit;

  assign w_tick    = (r_presc == PRESC_LAST);
  assign w_wrap    = w_tick && (r_idx == IDX_LAST);
  assign w_idx_nxt = (r_idx == IDX_LAST) ? {IW{1'b0}} : r_idx + IW'(1);

  // Next shadow: a load on the wrap edge bypasses pending so it is shown immediately.
  always_comb begin
    w_shadow_val_nxt = r_shadow_val;
    w_shadow_dp_nxt  = r_shadow_dp;
    if (w_wrap) begin
      if (load) begin
        w_shadow_val_nxt = value;
        w_shadow_dp_nxt  = dp_mask;
      end else if (r_pend_valid) begin
        w_shadow_val_nxt = r_pend_val;
        w_shadow_dp_nxt  = r_pend_dp;
      end else begin
        w_shadow_val_nxt = r_shadow_val;
        w_shadow_dp_nxt  = r_shadow_dp;
      end
    end else begin
      w_shadow_val_nxt = r_shadow_val;
      w_shadow_dp_nxt  = r_shadow_dp;
    end
  end

  // Select the nibble, decimal point and anode for the slot about to be shown.
  always_comb begin
    w_nib    = 4'h0;
    w_dp_bit = 1'b0;
    w_onehot = {NUM_DIGITS{1'b0}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_onehot[k] = (IW'(k) == w_idx_nxt);
      w_nib       = w_nib | (w_onehot[k] ? w_shadow_val_nxt[4*k +: 4] : 4'h0);
      w_dp_bit    = w_dp_bit | (w_onehot[k] & w_shadow_dp_nxt[k]);
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] w_msd;

  // Most significant nonzero digit; digit 0 is the floor so a zero value still lights one digit.
  always_comb begin
    w_msd = {IW{1'b0}};
    for (int k = 1; k < NUM_DIGITS; k++) begin
      w_msd = (w_shadow_val_nxt[4*k +: 4] != 4'h0) ? IW'(k) : w_msd;
    end
    w_lit = (w_idx_nxt <= w_msd);
  end
`else
  assign w_lit = 1'b1;
`endif

  // Refresh prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_presc <= {PW{1'b0}};
    else if (w_tick) r_presc <= {PW{1'b0}};
    else             r_presc <= r_presc + PW'(1);
  end

  // Slot index and displayed shadow copy; the shadow only moves at a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= IDX_LAST;
      r_shadow_val <= {4*NUM_DIGITS{1'b0}};
      r_shadow_dp  <= {NUM_DIGITS{1'b0}};
    end else begin
      if (w_tick) r_idx <= w_idx_nxt;
      r_shadow_val <= w_shadow_val_nxt;
      r_shadow_dp  <= w_shadow_dp_nxt;
    end
  end

  // Pending buffer: last load in a frame wins; cleared whenever a wrap consumes or bypasses it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_val   <= {4*NUM_DIGITS{1'b0}};
      r_pend_dp    <= {NUM_DIGITS{1'b0}};
      r_pend_valid <= 1'b0;
    end else if (load && !w_wrap) begin
      r_pend_val   <= value;
      r_pend_dp    <= dp_mask;
      r_pend_valid <= 1'b1;
    end else if (w_wrap) begin
      r_pend_valid <= 1'b0;
    end
  end

  // Registered display outputs, refreshed on each tick edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dig        <= 4'h0;
      r_an         <= AN_POL;
      r_dp         <= ACTIVE_LOW;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (w_tick) begin
        r_dig <= w_nib;
        r_an  <= (w_lit ? w_onehot : {NUM_DIGITS{1'b0}}) ^ AN_POL;
        r_dp  <= (w_lit & w_dp_bit) ^ ACTIVE_LOW;
      end
    end
  end

  assign dig        = r_dig;
  assign an         = r_an;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux (4 digits, 4 clocks per slot, active-low) with a slot scoreboard.
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_mask = 4'b0000;
  logic        load = 1'b0;
  logic [3:0]  dig;
  logic [3:0]  an;
  logic        dp;
  logic        frame_done;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Tuple layout: {frame_done, dp, an[3:0], dig[3:0]}
  logic [9:0] q[$];
  logic [9:0] last_exp;
  localparam logic [9:0] RST_EXP = {1'b0, 1'b1, 4'b1111, 4'h0};

  always #5 clk = ~clk;

  seg_scan_mux #(
    .NUM_DIGITS(4),
    .CLK_DIV(4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .value(value),
    .dp_mask(dp_mask),
    .load(load),
    .dig(dig),
    .an(an),
    .dp(dp),
    .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    obs = {frame_done, dp, an, dig};
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed fd/dp/an/dig=%b/%b/%b/%h expected %b/%b/%b/%h", tag,
             obs[9], obs[8], obs[7:4], obs[3:0], exp[9], exp[8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [9:0] exp;
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed an=%b dig=%h expected a queued entry", tag, an, dig);
    end else begin
      exp = q.pop_front();
      last_exp = exp;
      chk(tag, exp);
    end
  endtask

  // Reference frame: digit k shown in slot k, optional leading-zero blanking.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] m);
    int msd;
    logic lit;
    logic [3:0] oh;
    logic [3:0] an_e;
    logic dp_e;
    msd = 0;
    for (int k = 1; k < 4; k++) if (v[4*k +: 4] != 4'h0) msd = k;
    for (int k = 0; k < 4; k++) begin
      lit = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
      lit = (k <= msd);
`endif
      oh   = 4'b0001 << k;
      an_e = lit ? ~oh : 4'b1111;
      dp_e = ~(lit & m[k]);
      q.push_back({(k == 0), dp_e, an_e, v[4*k +: 4]});
    end
  endtask

  // One slot period: hold checks on the first three cycles, scoreboard pop at the tick edge.
  task automatic slot(input string tag, input bit ld, input logic [15:0] v,
                      input logic [3:0] m, input int off);
    for (int c = 0; c < 4; c++) begin
      if (ld && c == off) begin
        value = v;
        dp_mask = m;
        load = 1'b1;
      end
      @(posedge clk);
      #1;
      load = 1'b0;
      if (c < 3) chk({tag, "_hold"}, {1'b0, last_exp[8:0]});
      else       pop_chk(tag);
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) slot(tag, 1'b0, 16'h0000, 4'b0000, 0);
  endtask

  initial begin
    last_exp = RST_EXP;
    #2 rst_n = 1'b0;
    #1;
    q.push_back(RST_EXP);
    pop_chk("reset_async");
    @(negedge clk);
    rst_n = 1'b1;

    push_frame(16'h1234, 4'b0100);
    push_frame(16'h1234, 4'b0100);
    slot("scan", 1'b1, 16'h1234, 4'b0100, 0);
    idle("scan", 7);

    push_frame(16'h1234, 4'b0100);
    idle("tear", 2);
    slot("tear", 1'b1, 16'hABCD, 4'b0001, 1);
    slot("tear", 1'b1, 16'h5555, 4'b1000, 2);

    push_frame(16'h5555, 4'b1000);
    push_frame(16'h00F0, 4'b0010);
    push_frame(16'h00F0, 4'b0010);
    idle("last_wins", 4);
    slot("coincident", 1'b1, 16'h00F0, 4'b0010, 3);
    idle("coincident", 7);

    push_frame(16'h00F0, 4'b0010);
    idle("pre_reset", 3);
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    q.push_back(RST_EXP);
    pop_chk("reset_mid");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    push_frame(16'h0000, 4'b0000);
    push_frame(16'h0050, 4'b0011);
    idle("post_reset", 3);
    slot("post_reset", 1'b1, 16'h0050, 4'b0011, 1);
    value = 16'hFFFF;
    dp_mask = 4'b1111;
    idle("no_load", 4);

    n_chk++;
    assert (q.size() == 0) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL sb_drain: observed %0d entries left expected 0", q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
